logic_op_pipe: RTL and testbench

//  Pipelined issue/retire stage wrapped around the bitwise logical unit (AND/OR/XOR).

---
 rtl/logic_op_pipe.sv | 143 ++++++++++++++
 tb/tb_logic_op_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// logic_op_pipe
//   Issue/retire stage wrapped around an external bitwise logical unit
//   (AND/OR/XOR). Ops arrive over a valid/ready handshake. Each op passes
//   through a 2-entry skid buffer, then operand register A, then result
//   register B:
//     - A drives the logical unit through lu_*.
//     - B captures lu_result together with a zero flag.
//   The stage sustains one op per cycle and supports full backpressure.
//
// Handshake rule (both sides): a transfer happens at a rising clk edge when
//   valid && ready. out_valid, out_result and out_zero stay stable until
//   out_ready is seen. in_ready comes from a register, gated only by flush,
//   and never depends on out_ready in the same cycle.
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   flush                 sync flush: drops every op in flight
//   in_valid/in_ready     upstream handshake
//   in_term0/1, in_sel    operands and op select (0=AND 1=OR 2,3=XOR)
//   lu_term0/1, lu_sel    to logical unit, driven from operand register A
//   lu_result             from logical unit (combinational)
//   out_valid/out_ready   downstream handshake
//   out_result, out_zero  registered result and its zero flag
//   op_count              completed output transfers, wraps
module logic_op_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_term0,
  input  logic [WIDTH-1:0] in_term1,
  input  logic [1:0]       in_sel,
  output logic [WIDTH-1:0] lu_term0,
  output logic [WIDTH-1:0] lu_term1,
  output logic [1:0]       lu_sel,
  input  logic [WIDTH-1:0] lu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int EW = 2 * WIDTH + 2;

  // Skid buffer: skid0 is always the oldest entry.
  logic [EW-1:0]    skid0, skid1;
  logic [1:0]       skid_cnt, skid_cnt_nxt;
  logic             ready_q;

  logic             a_valid;
  logic [WIDTH-1:0] a_term0, a_term1;
  logic [1:0]       a_sel;

  logic             b_valid;
  logic [WIDTH-1:0] b_result;
  logic             b_zero;
  logic [CNT_W-1:0] cnt;

  logic             in_fire, out_fire, b_load, a_free, pop, direct, push;
  logic [1:0]       wr_idx;
  logic [EW-1:0]    in_entry, a_src;

  assign in_ready = ready_q & ~flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = b_valid & out_ready;

  // Moves between internal registers are suppressed during flush.
  // Suppressing them keeps the data registers at their old values.
  assign b_load = a_valid & (~b_valid | out_ready) & ~flush;
  assign a_free = ~a_valid | b_load;
  assign pop    = a_free & (skid_cnt != 2'd0) & ~flush;
  // Bypass: with an empty skid buffer the input goes straight into A.
  assign direct = a_free & (skid_cnt == 2'd0) & in_fire;
  assign push   = in_fire & ~direct;

  // Slot that receives a pushed entry, after any pop in the same cycle.
  assign wr_idx   = skid_cnt - {1'b0, pop};
  assign in_entry = {in_sel, in_term1, in_term0};
  assign a_src    = pop ? skid0 : in_entry;

  always_comb begin
    skid_cnt_nxt = skid_cnt;
    if (flush) skid_cnt_nxt = 2'd0;
    else       skid_cnt_nxt = skid_cnt - {1'b0, pop} + {1'b0, push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
      a_valid  <= 1'b0;
      a_term0  <= '0;
      a_term1  <= '0;
      a_sel    <= 2'd0;
      b_valid  <= 1'b0;
      b_result <= '0;
      b_zero   <= 1'b1;
      cnt      <= '0;
    end else begin
      // Registered ready: drops once the skid buffer will hold two entries.
      ready_q  <= (skid_cnt_nxt != 2'd2);
      skid_cnt <= skid_cnt_nxt;

      if (pop) skid0 <= skid1;
      // This write comes after the shift, so it overrides skid0 on pop+push.
      if (push) begin
        if (wr_idx == 2'd0) skid0 <= in_entry;
        else                skid1 <= in_entry;
      end

      if (flush)       a_valid <= 1'b0;
      else if (a_free) a_valid <= pop | direct;
      if (pop | direct) {a_sel, a_term1, a_term0} <= a_src;

      if (flush)         b_valid <= 1'b0;
      else if (b_load)   b_valid <= 1'b1;
      else if (out_fire) b_valid <= 1'b0;
      if (b_load) begin
        b_result <= lu_result;
        b_zero   <= (lu_result == '0);
      end

      // An output handshake still completes during a flush cycle.
      if (out_fire) cnt <= cnt + 1'b1;
    end
  end

  assign lu_term0   = a_term0;
  assign lu_term1   = a_term1;
  assign lu_sel     = a_sel;
  assign out_valid  = b_valid;
  assign out_result = b_result;
  assign out_zero   = b_zero;
  assign op_count   = cnt;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe
//   Testbench for logic_op_pipe. It models the logical unit, drives ops, and
//   uses a scoreboard queue to check results in order.
module tb_logic_op_pipe;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk, rst_n, flush, in_valid, in_ready;
  logic [W-1:0]  in_term0, in_term1, lu_term0, lu_term1, lu_result, out_result;
  logic [1:0]    in_sel, lu_sel;
  logic          out_valid, out_ready, out_zero;
  logic [CW-1:0] op_count;

  logic          rnd_mode, rnd_ready, man_ready;
  int            total, bad;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] mcount;

  logic          prev_stall, prev_zero;
  logic [W-1:0]  prev_res, e;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, b, input logic [1:0] s);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign lu_result = ref_op(lu_term0, lu_term1, lu_sel);
  assign out_ready = rnd_mode ? rnd_ready : man_ready;

  logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_term0(in_term0), .in_term1(in_term1), .in_sel(in_sel),
    .lu_term0(lu_term0), .lu_term1(lu_term1), .lu_sel(lu_sel),
    .lu_result(lu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .op_count(op_count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_ready = ($urandom_range(0, 99) < 55);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard (samples on the falling edge)
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_result", 64'(out_result), 64'(prev_res));
        check("hold_zero", 64'(out_zero), 64'(prev_zero));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h expected none", out_result);
        end else begin
          e = exp_q.pop_front();
          check("out_result", 64'(out_result), 64'(e));
          check("out_zero", 64'(out_zero), 64'(e == '0));
          check("op_count", 64'(op_count), 64'(mcount));
          mcount++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_op(in_term0, in_term1, in_sel));
      // A flush drops everything still in flight.
      if (flush) exp_q.delete();
      prev_stall = out_valid && !out_ready && !flush;
      prev_res   = out_result;
      prev_zero  = out_zero;
    end
  end

  // Driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_term0 = a;
    in_term1 = b;
    in_sel   = s;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] v, input logic z);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen = 1'b1;
        check(name, 64'(out_result), 64'(v));
        check({name, "_zero"}, 64'(out_zero), 64'(z));
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no output expected %0h", name, v);
    end
  endtask

  task automatic wait_idle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(posedge clk);
      #2;
      idle = (exp_q.size() == 0) && !out_valid;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Test sequence
  initial begin
    logic          r, fired;
    int            acc;
    logic [CW-1:0] mc0;
    logic [W-1:0]  ft0, ft1;

    total = 0; bad = 0; mcount = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_term0 = '0; in_term1 = '0; in_sel = 2'd0;
    man_ready = 1'b1; rnd_mode = 1'b0; prev_stall = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd1);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Test 1: latency and a short stream
    send(32'hFFFF0000, 32'h0F0F0F0F, 2'd0);
    @(negedge clk);
    check("lat_early_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_result", 64'(out_result), 64'h0F0F0000);
    @(posedge clk);
    #1;
    send(32'hFFFF0000, 32'h0F0F0F0F, 2'd1);
    send(32'hFFFF0000, 32'h0F0F0F0F, 2'd2);
    wait_idle(50);
    check("count_after_3", 64'(op_count), 64'd3);

    // Test 2: sel=3 behaves as XOR and passes through unchanged
    send(32'hAAAAAAAA, 32'hFFFFFFFF, 2'd3);
    @(negedge clk);
    check("lu_sel_3", 64'(lu_sel), 64'd3);
    check("lu_term0", 64'(lu_term0), 64'hAAAAAAAA);
    check("lu_term1", 64'(lu_term1), 64'hFFFFFFFF);
    expect_out("sel3_result", 32'h55555555, 1'b0);

    // Test 3: zero flag
    @(posedge clk);
    #1;
    send(32'h00001234, 32'h0, 2'd0);
    expect_out("and_zero", 32'h0, 1'b1);
    @(posedge clk);
    #1;
    send(32'h1, 32'h0, 2'd1);
    expect_out("or_nonzero", 32'h1, 1'b0);
    wait_idle(50);

    // Test 4: fill under backpressure, then drain with no gaps
    man_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_term0 = $urandom; in_term1 = $urandom; in_sel = 2'($urandom_range(0, 3));
    for (int i = 0; i < 20 && acc < 4; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        in_term0 = $urandom; in_term1 = $urandom; in_sel = 2'($urandom_range(0, 3));
      end
    end
    check("fill_accepts", 64'(acc), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready_low", 64'(in_ready), 64'd0);
      check("full_holding", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1 man_ready = 1'b1;
    fired = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_no_gap", 64'(out_valid), 64'd1);
      r = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        fired = 1'b1;
        in_valid = 1'b0;
      end
    end
    check("fifth_accepted", 64'(fired), 64'd1);
    in_valid = 1'b0;
    wait_idle(50);

    // Test 5: random traffic against the reference queue
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      ft0 = $urandom;
      ft1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      send(ft0, ft1, 2'($urandom_range(0, 3)));
    end
    wait_idle(500);
    rnd_mode  = 1'b0;
    man_ready = 1'b1;

    // Test 6a: flush with three ops in flight; the head still retires
    man_ready = 1'b0;
    ft0 = $urandom; ft1 = $urandom;
    send(ft0, ft1, 2'd2);
    send($urandom, $urandom, 2'd0);
    send($urandom, $urandom, 2'd1);
    mc0 = mcount;
    flush = 1'b1;
    man_ready = 1'b1;
    in_valid = 1'b1;
    in_term0 = $urandom; in_term1 = $urandom; in_sel = 2'd1;
    @(negedge clk);
    check("flush_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid_cleared", 64'(out_valid), 64'd0);
    check("flush_ready_back", 64'(in_ready), 64'd1);
    check("flush_counted", 64'(op_count), 64'(mc0 + 1'b1));
    check("flush_data_kept", 64'(out_result), 64'(ft0 ^ ft1));
    wait_idle(50);

    // Test 6b: asynchronous reset mid-stream
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_term0 = $urandom; in_term1 = $urandom; in_sel = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_result", 64'(out_result), 64'd0);
    check("mid_rst_out_zero", 64'(out_zero), 64'd1);
    check("mid_rst_op_count", 64'(op_count), 64'd0);
    check("mid_rst_lu_term0", 64'(lu_term0), 64'd0);
    check("mid_rst_lu_sel", 64'(lu_sel), 64'd0);
    in_valid = 1'b0;
    exp_q.delete();
    mcount = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 6c: op_count wrap at full throughput
    acc = 0;
    in_valid = 1'b1;
    in_term0 = $urandom; in_term1 = $urandom; in_sel = 2'($urandom_range(0, 3));
    for (int i = 0; i < 70000 && acc < 65535; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        in_term0 = $urandom; in_term1 = $urandom; in_sel = 2'($urandom_range(0, 3));
      end
    end
    in_valid = 1'b0;
    wait_idle(50);
    check("count_ffff", 64'(op_count), 64'hFFFF);
    send(32'h5, 32'h3, 2'd2);
    wait_idle(50);
    check("count_wrap", 64'(op_count), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
